// File: rtl/c17_misr_compactor.sv
// c17_misr_compactor: folds the c17 core outputs (G22, G23) into a Galois MISR
// and compares the final signature against GOLDEN after NUM_PATTERNS accepts.
// Latency: an accept at edge k updates signature at edge k; the final accept at
// edge k enters CHECK, and done/pass are valid after edge k+1.
// Backpressure: in_ready is high only in RUN; in_valid in any other state is ignored.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin a run (honoured in IDLE or DONE only)
//   in_valid, in_ready   response handshake; accept = in_valid && in_ready
//   G22, G23             c17 outputs folded into signature bits 0 and 1
//   busy, done, pass     run in progress / run finished / signature == GOLDEN
//   signature, count     current MISR contents / patterns accepted this run
module c17_misr_compactor #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] POLY         = 16'hB400,
   parameter logic [WIDTH-1:0] SEED         = 16'hFFFF,
   parameter int               NUM_PATTERNS = 32,
   parameter logic [WIDTH-1:0] GOLDEN       = 16'h0000
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              G22,
   input  logic                              G23,
   output logic                              busy,
   output logic                              done,
   output logic                              pass,
   output logic [WIDTH-1:0]                  signature,
   output logic [$clog2(NUM_PATTERNS+1)-1:0] count
);

   localparam int CW = $clog2(NUM_PATTERNS + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic             accept;
   logic [WIDTH-1:0] misr_next;

   // in_ready is a registered copy of (state == RUN), so this is the handshake.
   assign accept = in_valid && in_ready;

   // Galois step: shift right, apply taps when the bit leaving position 0 is set,
   // then inject the two core outputs into the low bits.
   always_comb begin
      misr_next = signature >> 1;
      if (signature[0]) begin
         misr_next = misr_next ^ POLY;
      end
      misr_next[0] = misr_next[0] ^ G22;
      misr_next[1] = misr_next[1] ^ G23;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         signature <= SEED;
         count     <= '0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= RUN;
                  signature <= SEED;
                  count     <= '0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
               end
            end
            RUN: begin
               if (accept) begin
                  signature <= misr_next;
                  count     <= count + CW'(1);
                  // Drop in_ready on the final accept so count cannot pass NUM_PATTERNS.
                  if (count == LAST) begin
                     state    <= CHECK;
                     in_ready <= 1'b0;
                  end
               end
            end
            CHECK: begin
               pass  <= (signature == GOLDEN);
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= DONE;
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule
